fpu_req_sequencer: RTL and testbench

Issue-side companion to the FPNew blackbox wrapper: accepts FP operation commands from a core, drives the FPU input handshake with round-robin tags, and collects results in a tag-indexed reorder buffer. Results are returned to the requester strictly in issue order. It also sequences a pipeline flush and the drain that follows it. The block sits between a Composer core's command stream and one FPNew instance.

---
 rtl/fpu_req_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fpu_req_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_sequencer.sv
// In-order issue/retire front end for one FPNew instance, with a tag-indexed reorder buffer.
// Define FPU_SEQ_ERRCHK_EN to drop unexpected completions and raise a sticky err_o.
module fpu_req_sequencer #(
  parameter int FLEN      = 32,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [3*FLEN-1:0]    cmd_operands_i,
  input  logic [3:0]           cmd_op_i,
  input  logic                 cmd_op_mod_i,
  input  logic [2:0]           cmd_rnd_i,
  output logic                 fpu_in_valid_o,
  input  logic                 fpu_in_ready_i,
  output logic [3*FLEN-1:0]    fpu_operands_o,
  output logic [3:0]           fpu_op_o,
  output logic                 fpu_op_mod_o,
  output logic [2:0]           fpu_rnd_mode_o,
  output logic [TAG_WIDTH-1:0] fpu_tag_o,
  output logic                 fpu_flush_o,
  input  logic                 fpu_out_valid_i,
  output logic                 fpu_out_ready_o,
  input  logic [FLEN-1:0]      fpu_result_i,
  input  logic [4:0]           fpu_status_i,
  input  logic [TAG_WIDTH-1:0] fpu_tag_i,
  input  logic                 fpu_busy_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [FLEN-1:0]      rsp_result_o,
  output logic [4:0]           rsp_status_o,
  input  logic                 flush_i,
  output logic                 idle_o,
  output logic                 err_o
);

  // state    | meaning
  // ST_RUN   | issue commands, collect results, retire in order
  // ST_FLUSH | one-cycle FPU flush, ROB and pointers cleared
  // ST_DRAIN | discard FPU results until the FPU is quiet
  localparam int DEPTH = 1 << TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] CNT_FULL = (TAG_WIDTH+1)'(DEPTH);
  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_FLUSH = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  logic [1:0]           r_state;
  logic [TAG_WIDTH-1:0] r_head;
  logic [TAG_WIDTH-1:0] r_tail;
  logic [TAG_WIDTH:0]   r_count;
  logic [DEPTH-1:0]     r_rob_valid;
  logic [FLEN-1:0]      r_rob_result [DEPTH];
  logic [4:0]           r_rob_status [DEPTH];

  logic w_run;
  logic w_not_full;
  logic w_issue;
  logic w_retire;
  logic w_write;

  assign w_run      = (r_state == ST_RUN);
  assign w_not_full = (r_count < CNT_FULL);

  assign fpu_in_valid_o = cmd_valid_i & w_not_full & ~flush_i & w_run;
  assign cmd_ready_o    = fpu_in_ready_i & w_not_full & ~flush_i & w_run;
  assign w_issue        = cmd_valid_i & cmd_ready_o;

  assign fpu_operands_o = cmd_operands_i;
  assign fpu_op_o       = cmd_op_i;
  assign fpu_op_mod_o   = cmd_op_mod_i;
  assign fpu_rnd_mode_o = cmd_rnd_i;
  assign fpu_tag_o      = r_tail;

  assign fpu_out_ready_o = 1'b1;
  assign fpu_flush_o     = (r_state == ST_FLUSH);
  assign idle_o          = w_run & (r_count == '0);

  assign rsp_valid_o  = r_rob_valid[r_head] & w_run;
  assign rsp_result_o = r_rob_result[r_head];
  assign rsp_status_o = r_rob_status[r_head];
  assign w_retire     = rsp_valid_o & rsp_ready_i;

`ifdef FPU_SEQ_ERRCHK_EN
  logic [TAG_WIDTH-1:0] w_offset;
  logic                 w_outstanding;
  logic                 w_unexpected;
  logic                 r_err;

  // Outstanding tags are the count entries starting at head.
  assign w_offset      = fpu_tag_i - r_head;
  assign w_outstanding = ({1'b0, w_offset} < r_count);
  assign w_unexpected  = r_rob_valid[fpu_tag_i] | ~w_outstanding;
  assign w_write       = w_run & fpu_out_valid_i & ~w_unexpected;
  assign err_o         = r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_run & fpu_out_valid_i & w_unexpected) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_write = w_run & fpu_out_valid_i;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_rob_result[fpu_tag_i] <= fpu_result_i;
      r_rob_status[fpu_tag_i] <= fpu_status_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_RUN;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rob_valid <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_retire) begin
            r_rob_valid[r_head] <= 1'b0;
            r_head              <= r_head + 1'b1;
          end
          if (w_write) begin
            r_rob_valid[fpu_tag_i] <= 1'b1;
          end
          if (w_issue) begin
            r_tail <= r_tail + 1'b1;
          end
          case ({w_issue, w_retire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
          if (flush_i) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_rob_valid <= '0;
          r_head      <= '0;
          r_tail      <= '0;
          r_count     <= '0;
          r_state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!fpu_busy_i && !fpu_out_valid_i) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Directed bench for fpu_req_sequencer: a per-cycle vector table plus hand-written
// multi-cycle sequences (full/wrap, backpressure, flush/drain, tag errors, reset).
module tb_fpu_req_sequencer;
  localparam int FLEN = 32;
  localparam int TW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            cmd_valid, cmd_ready;
  logic [3*FLEN-1:0] cmd_operands;
  logic [3:0]      cmd_op;
  logic            cmd_op_mod;
  logic [2:0]      cmd_rnd;
  logic            fpu_in_valid, fpu_in_ready;
  logic [3*FLEN-1:0] fpu_operands;
  logic [3:0]      fpu_op;
  logic            fpu_op_mod;
  logic [2:0]      fpu_rnd_mode;
  logic [TW-1:0]   fpu_tag;
  logic            fpu_flush;
  logic            fpu_out_valid, fpu_out_ready;
  logic [FLEN-1:0] fpu_result;
  logic [4:0]      fpu_status;
  logic [TW-1:0]   fpu_tag_in;
  logic            fpu_busy;
  logic            rsp_valid, rsp_ready;
  logic [FLEN-1:0] rsp_result;
  logic [4:0]      rsp_status;
  logic            flush;
  logic            idle, err;

  fpu_req_sequencer #(.FLEN(FLEN), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_operands_i(cmd_operands), .cmd_op_i(cmd_op), .cmd_op_mod_i(cmd_op_mod), .cmd_rnd_i(cmd_rnd),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod),
    .fpu_rnd_mode_o(fpu_rnd_mode), .fpu_tag_o(fpu_tag), .fpu_flush_o(fpu_flush),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
    .fpu_busy_i(fpu_busy),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .flush_i(flush), .idle_o(idle), .err_o(err)
  );

  typedef struct {
    logic        cv, ir, ov;
    logic [1:0]  otag;
    logic [31:0] ores;
    logic        rr;
    logic        e_cr, e_iv;
    logic [1:0]  e_tag;
    logic        e_rv;
    logic [31:0] e_res;
    logic        e_idle;
  } vec_t;

  vec_t vecs [15];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic cv, input logic ir, input logic ov, input logic [1:0] otag,
                        input logic [31:0] ores, input logic rr, input logic fl, input logic bz);
    cmd_valid     = cv;
    fpu_in_ready  = ir;
    fpu_out_valid = ov;
    fpu_tag_in    = otag;
    fpu_result    = ores;
    fpu_status    = 5'd0;
    rsp_ready     = rr;
    flush         = fl;
    fpu_busy      = bz;
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst idle", idle, 1);
    chk("rst flush_o", fpu_flush, 0);
    chk("rst out_ready", fpu_out_ready, 1);
    chk("rst err", err, 0);
    fpu_in_ready = 1'b0;
    #1;
    chk("rst cmd_ready follows in_ready", cmd_ready, 0);
    rst_n = 1'b1;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_vec(input int i);
    set_in(vecs[i].cv, vecs[i].ir, vecs[i].ov, vecs[i].otag, vecs[i].ores, vecs[i].rr, 0, 0);
    chk($sformatf("v%0d cmd_ready", i), cmd_ready, vecs[i].e_cr);
    chk($sformatf("v%0d in_valid", i), fpu_in_valid, vecs[i].e_iv);
    chk($sformatf("v%0d tag", i), fpu_tag, vecs[i].e_tag);
    chk($sformatf("v%0d rsp_valid", i), rsp_valid, vecs[i].e_rv);
    if (vecs[i].e_rv) chk($sformatf("v%0d rsp_result", i), rsp_result, vecs[i].e_res);
    chk($sformatf("v%0d idle", i), idle, vecs[i].e_idle);
    chk($sformatf("v%0d flush_o", i), fpu_flush, 0);
    tick;
  endtask

  initial begin
    //           cv ir ov otag ores          rr  cr iv tag rv res           idle
    vecs[0]  = '{0, 1, 0, 0, 32'h0,        0,  1, 0, 0, 0, 32'h0,        1};
    vecs[1]  = '{1, 1, 0, 0, 32'h0,        0,  1, 1, 0, 0, 32'h0,        1};
    vecs[2]  = '{0, 1, 1, 0, 32'h40400000, 0,  1, 0, 1, 0, 32'h0,        0};
    vecs[3]  = '{0, 1, 0, 0, 32'h0,        1,  1, 0, 1, 1, 32'h40400000, 0};
    vecs[4]  = '{0, 1, 0, 0, 32'h0,        0,  1, 0, 1, 0, 32'h0,        1};
    vecs[5]  = '{1, 1, 0, 0, 32'h0,        0,  1, 1, 0, 0, 32'h0,        1};
    vecs[6]  = '{1, 1, 0, 0, 32'h0,        0,  1, 1, 1, 0, 32'h0,        0};
    vecs[7]  = '{1, 1, 0, 0, 32'h0,        0,  1, 1, 2, 0, 32'h0,        0};
    vecs[8]  = '{0, 1, 1, 2, 32'hA,        1,  1, 0, 3, 0, 32'h0,        0};
    vecs[9]  = '{0, 1, 1, 0, 32'hB,        1,  1, 0, 3, 0, 32'h0,        0};
    vecs[10] = '{0, 1, 1, 1, 32'hC,        1,  1, 0, 3, 1, 32'hB,        0};
    vecs[11] = '{0, 1, 0, 0, 32'h0,        1,  1, 0, 3, 1, 32'hC,        0};
    vecs[12] = '{0, 1, 0, 0, 32'h0,        1,  1, 0, 3, 1, 32'hA,        0};
    vecs[13] = '{0, 1, 0, 0, 32'h0,        0,  1, 0, 3, 0, 32'h0,        1};
    vecs[14] = '{1, 0, 0, 0, 32'h0,        0,  0, 1, 3, 0, 32'h0,        1};

    cmd_operands = {32'h0, 32'h40000000, 32'h3F800000};
    cmd_op       = 4'd2;
    cmd_op_mod   = 1'b0;
    cmd_rnd      = 3'd0;
    @(negedge clk);
    do_reset;

    chk("pass a", fpu_operands[31:0], 32'h3F800000);
    chk("pass b", fpu_operands[63:32], 32'h40000000);
    chk("pass op", fpu_op, 4'd2);

    // Single op, then out-of-order return after a fresh reset
    for (int i = 0; i < 5; i++) apply_vec(i);
    do_reset;
    for (int i = 5; i < 15; i++) apply_vec(i);

    // Full ROB and tag wrap
    do_reset;
    for (int t = 0; t < 4; t++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("fill tag%0d", t), fpu_tag, t);
      chk($sformatf("fill ready%0d", t), cmd_ready, 1);
      tick;
    end
    set_in(1, 1, 1, 0, 32'h100, 0, 0, 0);
    chk("full cmd_ready", cmd_ready, 0);
    chk("full in_valid", fpu_in_valid, 0);
    tick;
    set_in(1, 1, 1, 1, 32'h101, 1, 0, 0);
    chk("full retire cmd_ready", cmd_ready, 0);
    chk("full retire rsp", rsp_result, 32'h100);
    tick;
    set_in(1, 1, 0, 0, 0, 1, 0, 0);
    chk("wrap cmd_ready", cmd_ready, 1);
    chk("wrap tag", fpu_tag, 0);
    chk("wrap rsp_valid", rsp_valid, 1);
    chk("wrap rsp", rsp_result, 32'h101);
    tick;

    // Backpressure with two results waiting
    set_in(0, 1, 1, 2, 32'h102, 0, 0, 0);
    chk("bp pre rsp_valid", rsp_valid, 0);
    tick;
    set_in(0, 1, 1, 3, 32'h103, 0, 0, 0);
    tick;
    for (int c = 0; c < 5; c++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("bp hold valid%0d", c), rsp_valid, 1);
      chk($sformatf("bp hold data%0d", c), rsp_result, 32'h102);
      tick;
    end
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("bp rsp1", rsp_result, 32'h102);
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("bp rsp2 valid", rsp_valid, 1);
    chk("bp rsp2", rsp_result, 32'h103);
    tick;
    set_in(0, 1, 1, 0, 32'h104, 1, 0, 0);
    fpu_status = 5'h11;
    #1;
    chk("late rsp_valid", rsp_valid, 0);
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("late rsp", rsp_result, 32'h104);
    chk("late status", rsp_status, 5'h11);
    tick;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    chk("drained idle", idle, 1);

    // Flush with three outstanding (tags 1,2,3)
    for (int t = 1; t < 4; t++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("fl issue tag%0d", t), fpu_tag, t);
      tick;
    end
    set_in(0, 1, 1, 1, 32'h300, 0, 0, 0);
    tick;
    set_in(1, 1, 0, 0, 0, 0, 1, 0);
    chk("flush cmd_ready", cmd_ready, 0);
    chk("flush in_valid", fpu_in_valid, 0);
    tick;
    set_in(1, 1, 1, 2, 32'h322, 1, 1, 1);
    chk("FLUSH flush_o", fpu_flush, 1);
    chk("FLUSH rsp_valid", rsp_valid, 0);
    chk("FLUSH cmd_ready", cmd_ready, 0);
    tick;
    set_in(1, 1, 1, 3, 32'h333, 1, 0, 1);
    chk("DRAIN flush_o", fpu_flush, 0);
    chk("DRAIN rsp_valid", rsp_valid, 0);
    chk("DRAIN in_valid", fpu_in_valid, 0);
    tick;
    set_in(0, 1, 1, 1, 32'h311, 1, 0, 0);
    chk("DRAIN2 rsp_valid", rsp_valid, 0);
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("DRAIN3 cmd_ready", cmd_ready, 0);
    chk("DRAIN3 idle", idle, 0);
    tick;
    set_in(1, 1, 0, 0, 0, 1, 0, 0);
    chk("resume idle", idle, 1);
    chk("resume cmd_ready", cmd_ready, 1);
    chk("resume tag", fpu_tag, 0);
    chk("resume rsp_valid", rsp_valid, 0);
    tick;
    set_in(0, 1, 1, 0, 32'h400, 1, 0, 0);
    chk("post-flush rsp_valid", rsp_valid, 0);
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("post-flush rsp", rsp_result, 32'h400);
    chk("post-flush err", err, 0);
    tick;

    // Duplicate completion for a single outstanding tag
    do_reset;
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    tick;
    set_in(0, 1, 1, 0, 32'h1FF, 0, 0, 0);
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    tick;
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    chk("dup issue tag", fpu_tag, 1);
    tick;
    set_in(0, 1, 1, 1, 32'h200, 0, 0, 0);
    tick;
    set_in(0, 1, 1, 1, 32'h201, 0, 0, 0);
    chk("dup first err", err, 0);
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("dup rsp_valid", rsp_valid, 1);
`ifdef FPU_SEQ_ERRCHK_EN
    chk("dup err", err, 1);
    chk("dup rsp kept first", rsp_result, 32'h200);
`else
    chk("dup err off", err, 0);
    chk("dup rsp overwritten", rsp_result, 32'h201);
`endif
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("dup no second rsp", rsp_valid, 0);
    chk("dup idle", idle, 1);
`ifdef FPU_SEQ_ERRCHK_EN
    set_in(0, 1, 1, 3, 32'h333, 1, 0, 0);
    tick;
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    chk("stray rsp_valid", rsp_valid, 0);
    chk("err sticky", err, 1);
`endif

    // Reset in the middle of an operation
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    tick;
    set_in(0, 1, 1, 2, 32'h500, 0, 0, 0);
    tick;
    rst_n = 1'b0;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    tick;
    chk("midrst rsp_valid", rsp_valid, 0);
    chk("midrst idle", idle, 1);
    chk("midrst err", err, 0);
    chk("midrst tag", fpu_tag, 0);
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
